// File: rtl/wave_info_pkg.sv
// Shared register-map constants and decode types for the waveform info register bank.
package wave_info_pkg;

  localparam int STRIDE_LOG2 = 2;
  localparam int REG_STRIDE  = 1 << STRIDE_LOG2;

  localparam logic [STRIDE_LOG2-1:0] OFS_DIV  = 2'd0;
  localparam logic [STRIDE_LOG2-1:0] OFS_GAIN = 2'd1;
  localparam logic [STRIDE_LOG2-1:0] OFS_PLO  = 2'd2;
  localparam logic [STRIDE_LOG2-1:0] OFS_PHI  = 2'd3;

  localparam logic [1:0] OFS_STATUS = 2'd0;
  localparam logic [1:0] OFS_CTRL   = 2'd1;
  localparam logic [1:0] OFS_ID     = 2'd2;

  localparam logic [31:0] UNMAPPED_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_DIV,
    SEL_GAIN,
    SEL_PLO,
    SEL_PHI,
    SEL_STATUS,
    SEL_CTRL,
    SEL_ID,
    SEL_NONE
  } reg_sel_e;

endpackage

// File: rtl/wave_info_regbank_if.sv
// MCU-side parallel bus: address latch, write strobe (rd_en), read strobe (wr_en).
interface wave_info_regbank_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  addr_en;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output addr_en, rd_en, wr_en, rd_data, input wr_data);
  modport slave  (input addr_en, rd_en, wr_en, rd_data, output wr_data);
endinterface

// File: rtl/wave_info_chan.sv
// Per-channel period high-word shadow and sticky "new period" flag.
module wave_info_chan #(
  parameter int HI_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                capture,
  input  logic                clear,
  input  logic                set,
  input  logic [HI_WIDTH-1:0] period_hi,
  output logic [HI_WIDTH-1:0] hi_shadow,
  output logic                new_flag
);

  // A fresh period pulse outranks a clear-on-read landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_shadow <= '0;
      new_flag  <= 1'b0;
    end else if (en) begin
      if (capture) hi_shadow <= period_hi;
      if (set)        new_flag <= 1'b1;
      else if (clear) new_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/wave_info_regbank.sv
// Multi-channel waveform info register bank: address decode, read mux, ctrl word.
module wave_info_regbank
  import wave_info_pkg::*;
#(
  parameter int                    NUM_CH        = 4,
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    COUNTER_WIDTH = 18,
  parameter int                    DIV_WIDTH     = 12,
  parameter int                    GAIN_WIDTH    = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 16'hA502
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  wave_info_regbank_if.slave              bus,
  input  logic [NUM_CH*DIV_WIDTH-1:0]     div,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]    gain_ctrl,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] period,
  input  logic [NUM_CH-1:0]               period_upd,
  output logic [DATA_WIDTH-1:0]           ctrl,
  output logic                            ctrl_wr
);

  localparam int HI_WIDTH = COUNTER_WIDTH - DATA_WIDTH;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DATA_WIDTH-1:0] G_BASE = DATA_WIDTH'(REG_STRIDE * NUM_CH);

  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_value;
  reg_sel_e              sel;
  logic [CH_W-1:0]       ch;
  logic                  read_hit;
  logic                  write_hit;

  logic [DIV_WIDTH-1:0]  div_ch    [NUM_CH];
  logic [GAIN_WIDTH-1:0] gain_ch   [NUM_CH];
  logic [DATA_WIDTH-1:0] plo_ch    [NUM_CH];
  logic [HI_WIDTH-1:0]   hi_shadow [NUM_CH];
  logic [NUM_CH-1:0]     new_flag;

  assign read_hit    = en && bus.wr_en;
  assign write_hit   = en && bus.rd_en;
  assign bus.wr_data = rd_q;

  always_comb begin
    sel = SEL_NONE;
    ch  = '0;
    if (addr < G_BASE) begin
      ch = addr[CH_W+STRIDE_LOG2-1:STRIDE_LOG2];
      case (addr[STRIDE_LOG2-1:0])
        OFS_DIV:  sel = SEL_DIV;
        OFS_GAIN: sel = SEL_GAIN;
        OFS_PLO:  sel = SEL_PLO;
        OFS_PHI:  sel = SEL_PHI;
        default:  sel = SEL_NONE;
      endcase
    end else if (addr == G_BASE + DATA_WIDTH'(OFS_STATUS)) begin
      sel = SEL_STATUS;
    end else if (addr == G_BASE + DATA_WIDTH'(OFS_CTRL)) begin
      sel = SEL_CTRL;
    end else if (addr == G_BASE + DATA_WIDTH'(OFS_ID)) begin
      sel = SEL_ID;
    end
  end

  always_comb begin
    rd_value = UNMAPPED_VALUE[DATA_WIDTH-1:0];
    case (sel)
      SEL_DIV:    rd_value = DATA_WIDTH'(div_ch[ch]);
      SEL_GAIN:   rd_value = DATA_WIDTH'(gain_ch[ch]);
      SEL_PLO:    rd_value = plo_ch[ch];
      SEL_PHI:    rd_value = DATA_WIDTH'(hi_shadow[ch]);
      SEL_STATUS: rd_value = DATA_WIDTH'(new_flag);
      SEL_CTRL:   rd_value = ctrl;
      SEL_ID:     rd_value = ID_VALUE;
      default:    rd_value = UNMAPPED_VALUE[DATA_WIDTH-1:0];
    endcase
  end

  // Clearing every flag on a STATUS read equals clearing exactly those returned as 1.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign div_ch[k]  = div[k*DIV_WIDTH +: DIV_WIDTH];
    assign gain_ch[k] = gain_ctrl[k*GAIN_WIDTH +: GAIN_WIDTH];
    assign plo_ch[k]  = period[k*COUNTER_WIDTH +: DATA_WIDTH];

    wave_info_chan #(
      .HI_WIDTH(HI_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .capture  (read_hit && (sel == SEL_PLO) && (ch == CH_W'(k))),
      .clear    (read_hit && (sel == SEL_STATUS)),
      .set      (period_upd[k]),
      .period_hi(period[k*COUNTER_WIDTH+DATA_WIDTH +: HI_WIDTH]),
      .hi_shadow(hi_shadow[k]),
      .new_flag (new_flag[k])
    );
  end

  // Read and write both use the address held before this edge; addr_en beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      rd_q    <= '0;
      ctrl    <= '0;
      ctrl_wr <= 1'b0;
    end else begin
      ctrl_wr <= write_hit && (sel == SEL_CTRL);
      if (en) begin
        if (bus.addr_en)    addr <= bus.rd_data;
        else if (bus.wr_en) addr <= addr + DATA_WIDTH'(1);
        if (bus.wr_en) rd_q <= rd_value;
        if (bus.rd_en && (sel == SEL_CTRL)) ctrl <= bus.rd_data;
      end
    end
  end

endmodule

// File: tb/tb_wave_info_regbank.sv
// Scoreboard bench for wave_info_regbank: directed scenarios plus randomized bus traffic.
module tb_wave_info_regbank;

  typedef struct {
    logic [15:0] wr_data;
    logic [15:0] ctrl;
    logic        ctrl_wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [47:0] div = '0;
  logic [7:0]  gain_ctrl = '0;
  logic [71:0] period = '0;
  logic [3:0]  period_upd = '0;
  logic [15:0] ctrl;
  logic        ctrl_wr;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  int unsigned m_addr;
  logic [15:0] m_wr;
  logic [15:0] m_ctrl;
  logic        m_ctrl_wr;
  logic [1:0]  m_hi[4];
  logic [3:0]  m_flag;

  wave_info_regbank_if #(.DATA_WIDTH(16)) bus ();

  wave_info_regbank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .div       (div),
    .gain_ctrl (gain_ctrl),
    .period    (period),
    .period_upd(period_upd),
    .ctrl      (ctrl),
    .ctrl_wr   (ctrl_wr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] modelRead(input int unsigned a);
    int unsigned c;
    c = a / 4;
    if (a < 16) begin
      case (a % 4)
        0:       return {4'b0, div[c*12 +: 12]};
        1:       return {14'b0, gain_ctrl[c*2 +: 2]};
        2:       return period[c*18 +: 16];
        default: return {14'b0, m_hi[c]};
      endcase
    end
    if (a == 16) return {12'b0, m_flag};
    if (a == 17) return m_ctrl;
    if (a == 18) return 16'hA502;
    return 16'hFFFF;
  endfunction

  task automatic modelReset();
    m_addr = 0;
    m_wr = '0;
    m_ctrl = '0;
    m_ctrl_wr = 1'b0;
    m_flag = '0;
    for (int i = 0; i < 4; i++) m_hi[i] = '0;
  endtask

  task automatic modelStep(input logic e, input logic ae, input logic rd, input logic wr,
                           input logic [15:0] d, input logic [3:0] u);
    logic [15:0] v;
    m_ctrl_wr = 1'b0;
    if (e) begin
      v = modelRead(m_addr);
      if (wr) begin
        m_wr = v;
        if (m_addr < 16 && (m_addr % 4) == 2) m_hi[m_addr/4] = period[(m_addr/4)*18 + 16 +: 2];
        if (m_addr == 16) m_flag = m_flag & ~v[3:0];
      end
      if (rd && m_addr == 17) begin
        m_ctrl = d;
        m_ctrl_wr = 1'b1;
      end
      m_flag = m_flag | u;
      if (ae)      m_addr = 32'(d);
      else if (wr) m_addr = (m_addr + 1) % 65536;
    end
  endtask

  task automatic applyStimulus(input logic e, input logic ae, input logic rd, input logic wr,
                               input logic [15:0] d, input logic [3:0] u);
    en = e;
    bus.addr_en = ae;
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.rd_data = d;
    period_upd = u;
    modelStep(e, ae, rd, wr, d, u);
    @(posedge clk);
    sb_q.push_back('{wr_data: m_wr, ctrl: m_ctrl, ctrl_wr: m_ctrl_wr});
    #1;
    bus.addr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    period_upd = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("sb_wr_data", bus.wr_data, e.wr_data);
      checkOutput("sb_ctrl", ctrl, e.ctrl);
      checkOutput("sb_ctrl_wr", {15'b0, ctrl_wr}, {15'b0, e.ctrl_wr});
    end
  end

  initial begin
    logic [15:0] d;
    bus.addr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_data = '0;
    modelReset();
    div       = {12'hABC, 12'h789, 12'h456, 12'h123};
    gain_ctrl = {2'd3, 2'd2, 2'd1, 2'd2};
    period    = {18'h0, 18'h0, 18'h2_1234, 18'h1_5678};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_wr_data", bus.wr_data, 16'h0000);
    checkOutput("reset_ctrl", ctrl, 16'h0000);
    checkOutput("reset_ctrl_wr", {15'b0, ctrl_wr}, 16'h0000);

    // ID read
    applyStimulus(1, 1, 0, 0, 16'd18, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("id_read", bus.wr_data, 16'hA502);

    // Tear-free period read on channel 1
    applyStimulus(1, 1, 0, 0, 16'd6, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("plo_ch1", bus.wr_data, 16'h1234);
    period[35:18] = 18'h3_0000;
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("phi_ch1_shadow", bus.wr_data, 16'h0002);

    // Burst of channel 0 with auto-increment into channel 1
    applyStimulus(1, 1, 0, 0, 16'd0, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("burst_div0", bus.wr_data, 16'h0123);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("burst_gain0", bus.wr_data, 16'h0002);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("burst_plo0", bus.wr_data, 16'h5678);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("burst_phi0", bus.wr_data, 16'h0001);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("burst_addr4_div1", bus.wr_data, 16'h0456);

    // STATUS clear-on-read, then set-wins collision
    applyStimulus(1, 0, 0, 0, 16'd0, 4'b0100);
    applyStimulus(1, 1, 0, 0, 16'd16, 0);
    applyStimulus(1, 1, 0, 1, 16'd16, 0);
    checkOutput("status_first", bus.wr_data, 16'h0004);
    applyStimulus(1, 1, 0, 1, 16'd16, 0);
    checkOutput("status_cleared", bus.wr_data, 16'h0000);
    applyStimulus(1, 0, 0, 0, 16'd0, 4'b0100);
    applyStimulus(1, 1, 0, 1, 16'd16, 4'b0100);
    checkOutput("status_collide_first", bus.wr_data, 16'h0004);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("status_set_wins", bus.wr_data, 16'h0004);

    // CTRL write, dropped write, unmapped read, write+read collision
    applyStimulus(1, 1, 0, 0, 16'd17, 0);
    applyStimulus(1, 0, 1, 0, 16'h00A5, 0);
    checkOutput("ctrl_written", ctrl, 16'h00A5);
    checkOutput("ctrl_wr_pulse", {15'b0, ctrl_wr}, 16'h0001);
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    checkOutput("ctrl_wr_single", {15'b0, ctrl_wr}, 16'h0000);
    applyStimulus(1, 1, 0, 0, 16'd0, 0);
    applyStimulus(1, 0, 1, 0, 16'h1234, 0);
    checkOutput("ro_write_ctrl", ctrl, 16'h00A5);
    applyStimulus(1, 1, 0, 0, 16'h7FFF, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("unmapped_read", bus.wr_data, 16'hFFFF);
    applyStimulus(1, 1, 0, 0, 16'd17, 0);
    applyStimulus(1, 0, 1, 1, 16'h005A, 0);
    checkOutput("ctrl_old_on_collide", bus.wr_data, 16'h00A5);
    checkOutput("ctrl_new_on_collide", ctrl, 16'h005A);

    // Address wrap at the top of the space
    applyStimulus(1, 1, 0, 0, 16'hFFFF, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    checkOutput("wrap_to_div0", bus.wr_data, 16'h0123);

    // Enable low: everything held
    applyStimulus(0, 1, 0, 0, 16'd18, 4'b1111);
    applyStimulus(0, 0, 1, 1, 16'hBEEF, 0);
    checkOutput("en_low_wr_data", bus.wr_data, 16'h0123);
    checkOutput("en_low_ctrl", ctrl, 16'h005A);

    // Reset mid-burst
    applyStimulus(1, 1, 0, 0, 16'd0, 0);
    applyStimulus(1, 0, 0, 1, 16'd0, 4'b0010);
    applyStimulus(1, 0, 0, 1, 16'd0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_data", bus.wr_data, 16'h0000);
    checkOutput("midrst_ctrl", ctrl, 16'h0000);
    checkOutput("midrst_ctrl_wr", {15'b0, ctrl_wr}, 16'h0000);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic e, ae, rd, wr;
      logic [3:0] u;
      if ($urandom_range(0, 7) == 0) begin
        div[31:0]  = $urandom;
        div[47:32] = 16'($urandom);
        gain_ctrl  = 8'($urandom);
        period[31:0]  = $urandom;
        period[63:32] = $urandom;
        period[71:64] = 8'($urandom);
      end
      e  = ($urandom_range(0, 9) != 0);
      ae = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 5) == 0);
      wr = ($urandom_range(0, 1) == 0);
      u  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      case ($urandom_range(0, 5))
        0:       d = 16'h7FFF;
        1:       d = 16'($urandom);
        default: d = 16'($urandom_range(0, 20));
      endcase
      applyStimulus(e, ae, rd, wr, d, u);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0 pending", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_info_regbank.md
# wave_info_regbank

Multi-channel register bank that lets the MCU read back per-channel waveform measurement data: divider, gain state, period counter. It also gives the MCU one writable control word. It sits between the parallel MCU bus front-end and the per-channel measurement cores. It adds three things over a single-channel readout:
- tear-free wide-period reads,
- per-channel "new period" flags,
- address auto-increment for burst reads.

## Interface
Parameters:
- NUM_CH, 4: number of measurement channels; 1..DATA_WIDTH.
- DATA_WIDTH, 16: bus data width.
- COUNTER_WIDTH, 18: period counter width; DATA_WIDTH < COUNTER_WIDTH <= 2*DATA_WIDTH.
- DIV_WIDTH, 12: divider field width; <= DATA_WIDTH.
- GAIN_WIDTH, 2: gain control field width; <= DATA_WIDTH.
- ID_VALUE, 16'hA502: constant returned by the ID register.

Ports:
- clk  in  1  system clock. One clock domain; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low, all state holds and bus strobes are ignored.
- addr_en  in  1  latch rd_data as the current address.
- rd_en  in  1  MCU write strobe: rd_data is written to the register at the current address.
- wr_en  in  1  MCU read strobe: wr_data is loaded from the register at the current address.
- rd_data  in  DATA_WIDTH  bus data from the MCU (address or write data).
- wr_data  out  DATA_WIDTH  registered read-back data to the MCU.
- div  in  NUM_CH*DIV_WIDTH  per-channel divider; channel k occupies bits [k*DIV_WIDTH +: DIV_WIDTH].
- gain_ctrl  in  NUM_CH*GAIN_WIDTH  per-channel gain state; same packing as div.
- period  in  NUM_CH*COUNTER_WIDTH  per-channel period count; same packing as div.
- period_upd  in  NUM_CH  one-cycle pulse per channel when its period value is refreshed.
- ctrl  out  DATA_WIDTH  MCU-written control word.
- ctrl_wr  out  1  one-cycle pulse on the cycle after ctrl is updated.

## Operation
Address map: channel k base = 4*k. G = 4*NUM_CH.
- base+0 DIV: zero-extended div[k]; read-only.
- base+1 GAIN: zero-extended gain_ctrl[k]; read-only.
- base+2 PERIOD_LO: period[k][DATA_WIDTH-1:0]. The same read captures period[k][COUNTER_WIDTH-1:DATA_WIDTH] into that channel's hi_shadow.
- base+3 PERIOD_HI: zero-extended hi_shadow[k]. Reading LO then HI therefore returns one coherent sample.
- G+0 STATUS: bit k = new_flag[k]; bits >= NUM_CH read 0. Clear-on-read: every flag returned as 1 is cleared.
- G+1 CTRL: read/write.
- G+2 ID: returns ID_VALUE.
- Any other address reads as all-ones. Writes to read-only or unmapped addresses are dropped without side effects.

Address register:
- addr_en loads rd_data into the address register.
- Each wr_en without addr_en in the same cycle post-increments the address. The address wraps at 2^DATA_WIDTH.
- rd_en does not increment the address.

Flags:
- period_upd[k] sets new_flag[k].
- If a set and a clear-on-read hit the same flag in the same cycle, the set wins and the flag stays 1.

Simultaneous strobes:
- addr_en with wr_en: the read uses the old address, then the new address is loaded; no increment.
- addr_en with rd_en: the write uses the old address.
- rd_en with wr_en to CTRL: wr_data returns the old ctrl value.

## Timing
- Reset values: wr_data=0, ctrl=0, ctrl_wr=0, address=0, all hi_shadow=0, all new_flag=0.
- Read latency: wr_data is valid on the first clk edge after the wr_en cycle and holds until the next accepted wr_en.
- Write latency: ctrl updates on the edge after the rd_en cycle; ctrl_wr is high for exactly that following cycle.
- hi_shadow and the STATUS clear update on the same edge as wr_data.
- Reset asserted mid-burst returns all state to reset values immediately.
- With en low: strobes are ignored, period_upd pulses are lost, and outputs hold. ctrl_wr is still forced low after its single cycle.

## Structure
- Shared package wave_info_pkg holds:
  - per-channel register offsets (OFS_DIV=0, OFS_GAIN=1, OFS_PLO=2, OFS_PHI=3);
  - the register stride (4);
  - global offsets (OFS_STATUS=0, OFS_CTRL=1, OFS_ID=2);
  - the unmapped read value.
- One sub-module, wave_info_chan: per-channel hi_shadow and new_flag logic, instantiated NUM_CH times in a generate loop. The top level holds address decode, the read mux and ctrl.

## Test plan
- Reset, then read the ID register (addr_en, data=G+2; wr_en) -> wr_data=16'hA502; all other outputs 0.
- Channel 1 with period=18'h2_1234: read addr 6 (PERIOD_LO), change period to 18'h3_0000, then read addr 7 (PERIOD_HI) -> reads return 16'h1234 then 16'h0002.
- Burst read: addr_en with data 0, then 4 consecutive wr_en pulses -> wr_data returns DIV, GAIN, PLO, PHI of channel 0 in order; the address ends at 4.
- period_upd[2] pulse, then read STATUS twice -> 16'h0004, then 16'h0000. A period_upd[2] coincident with the first read leaves the second read at 16'h0004.
- Write 16'h00A5 to CTRL -> ctrl=16'h00A5 with a single-cycle ctrl_wr. A write to addr 0 leaves every output unchanged. A read of addr 16'h7FFF returns 16'hFFFF.
- Hold en low during addr_en, rd_en and wr_en -> no output changes. Assert rst_n low mid-burst -> all outputs 0 immediately.
